// File: rtl/alu_pkg.sv
// Shared types and constants for the streaming ALU: op-code enums, channel
// indices, the b-operand guard value and the interrupt index helper.
package alu_pkg;

  typedef enum logic [1:0] {
    A_AND  = 2'd0,
    A_NAND = 2'd1,
    A_OR   = 2'd2,
    A_XOR  = 2'd3
  } op_a_e;

  typedef enum logic [1:0] {
    B_XNOR = 2'd0,
    B_AND  = 2'd1,
    B_NOR  = 2'd2,
    B_OR   = 2'd3
  } op_b_e;

  localparam logic CHAN_A  = 1'b0;
  localparam logic CHAN_B  = 1'b1;
  localparam int   N_IRQ   = 8;
  localparam int   GUARD_B = 3;

  // Interrupt match/mask slot for a given channel and op: {chan, op}.
  function automatic logic [2:0] irq_idx(input logic chan, input logic [1:0] op);
    return {chan, op};
  endfunction

endpackage

// File: rtl/alu_stream_core.sv
// Combinational compute stage: decodes channel/op, evaluates the result,
// flags whether the command produces a result and reports its irq slot.
module alu_stream_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             enable_a,
  input  logic             enable_b,
  input  logic [1:0]       op_a,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             produce,
  output logic [2:0]       idx
);

  logic b_guard;
  logic b_zero;
  logic a_ones;

  assign b_guard = (b == WIDTH'(GUARD_B));
  assign b_zero  = (b == '0);
  assign a_ones  = &a;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    result  = '0;
    produce = 1'b0;
    idx     = '0;
    if (enable_a && !enable_b) begin
      idx     = irq_idx(CHAN_A, op_a);
      produce = 1'b1;
      unique case (op_a_e'(op_a))
        A_AND: begin
          result  = a & b;
          produce = !b_zero;
        end
        A_NAND: begin
          result  = ~(a & b);
          produce = !a_ones && !b_guard;
        end
        A_OR:  result = a | b;
        A_XOR: result = a ^ b;
      endcase
    end else if (enable_b && !enable_a) begin
      idx     = irq_idx(CHAN_B, op_b);
      produce = 1'b1;
      unique case (op_b_e'(op_b))
        B_XNOR: result = ~(a ^ b);
        B_AND: begin
          result  = a & b;
          produce = !b_guard;
        end
        B_NOR: begin
          result  = ~(a | b);
          produce = !b_guard;
        end
        B_OR:  result = a | b;
      endcase
    end
  end

endmodule

// File: rtl/alu_stream.sv
// Streaming ALU top: valid/ready handshake, one-deep output register, sticky
// interrupt and saturating counters. Optional ALU_PARITY_EN adds alu_out_par.
module alu_stream
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   alu_clk,
  input  logic                   rst_n,
  input  logic                   alu_in_valid,
  output logic                   alu_in_ready,
  input  logic                   alu_enable_a,
  input  logic                   alu_enable_b,
  input  logic [1:0]             alu_op_a,
  input  logic [1:0]             alu_op_b,
  input  logic [WIDTH-1:0]       alu_in_a,
  input  logic [WIDTH-1:0]       alu_in_b,
  input  logic [N_IRQ*WIDTH-1:0] alu_irq_match,
  input  logic [N_IRQ-1:0]       alu_irq_mask,
  input  logic                   alu_irq_clr,
  output logic                   alu_out_valid,
  input  logic                   alu_out_ready,
  output logic [WIDTH-1:0]       alu_out,
  output logic                   alu_irq,
  output logic                   alu_drop,
  output logic [CNT_W-1:0]       alu_drop_cnt,
`ifdef ALU_PARITY_EN
  output logic                   alu_out_par,
`endif
  output logic [CNT_W-1:0]       alu_irq_cnt
);

  logic [WIDTH-1:0] result;
  logic             produce;
  logic [2:0]       idx;
  logic             accept;
  logic             produced;
  logic             dropped;
  logic             irq_set;
  logic [WIDTH-1:0] match_arr [N_IRQ];

  alu_stream_core #(.WIDTH(WIDTH)) u_core (
    .enable_a (alu_enable_a),
    .enable_b (alu_enable_b),
    .op_a     (alu_op_a),
    .op_b     (alu_op_b),
    .a        (alu_in_a),
    .b        (alu_in_b),
    .result   (result),
    .produce  (produce),
    .idx      (idx)
  );

  always_comb begin
    for (int i = 0; i < N_IRQ; i++) begin
      match_arr[i] = alu_irq_match[i*WIDTH +: WIDTH];
    end
  end

  // A stalled beat blocks new commands; a consumed beat frees the slot the same cycle.
  assign alu_in_ready = !alu_out_valid || alu_out_ready;
  assign accept       = alu_in_valid && alu_in_ready;
  assign produced     = accept && produce;
  assign dropped      = accept && !produce;
  assign irq_set      = produced && alu_irq_mask[idx] && (result == match_arr[idx]);

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out       <= '0;
      alu_out_valid <= 1'b0;
      alu_irq       <= 1'b0;
      alu_drop      <= 1'b0;
      alu_drop_cnt  <= '0;
      alu_irq_cnt   <= '0;
`ifdef ALU_PARITY_EN
      alu_out_par   <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      alu_drop <= dropped;

      // alu_out is left untouched on drops and handshakes; only a new result replaces it.
      if (produced) begin
        alu_out       <= result;
        alu_out_valid <= 1'b1;
`ifdef ALU_PARITY_EN
        alu_out_par   <= ^result;
`endif
      end else if (alu_out_ready) begin
        alu_out_valid <= 1'b0;
      end

      if (irq_set) begin
        alu_irq <= 1'b1;
      end else if (alu_irq_clr) begin
        alu_irq <= 1'b0;
      end

      if (dropped && !(&alu_drop_cnt)) begin
        alu_drop_cnt <= alu_drop_cnt + CNT_W'(1);
      end
      if (irq_set && !(&alu_irq_cnt)) begin
        alu_irq_cnt <= alu_irq_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_stream.sv
// Self-checking bench for alu_stream (WIDTH=8): reference model with a beat
// scoreboard, a constant vector table and hand-written corner sequences.
module tb_alu_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic              alu_clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              alu_in_valid = 1'b0;
  logic              alu_in_ready;
  logic              alu_enable_a = 1'b0;
  logic              alu_enable_b = 1'b0;
  logic [1:0]        alu_op_a = '0;
  logic [1:0]        alu_op_b = '0;
  logic [WIDTH-1:0]  alu_in_a = '0;
  logic [WIDTH-1:0]  alu_in_b = '0;
  logic [8*WIDTH-1:0] alu_irq_match = '0;
  logic [7:0]        alu_irq_mask = '0;
  logic              alu_irq_clr = 1'b0;
  logic              alu_out_valid;
  logic              alu_out_ready = 1'b1;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_irq;
  logic              alu_drop;
  logic [CNT_W-1:0]  alu_drop_cnt;
  logic [CNT_W-1:0]  alu_irq_cnt;
`ifdef ALU_PARITY_EN
  logic              alu_out_par;
`endif

  always #5 alu_clk = ~alu_clk;

  alu_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .alu_clk       (alu_clk),
    .rst_n         (rst_n),
    .alu_in_valid  (alu_in_valid),
    .alu_in_ready  (alu_in_ready),
    .alu_enable_a  (alu_enable_a),
    .alu_enable_b  (alu_enable_b),
    .alu_op_a      (alu_op_a),
    .alu_op_b      (alu_op_b),
    .alu_in_a      (alu_in_a),
    .alu_in_b      (alu_in_b),
    .alu_irq_match (alu_irq_match),
    .alu_irq_mask  (alu_irq_mask),
    .alu_irq_clr   (alu_irq_clr),
    .alu_out_valid (alu_out_valid),
    .alu_out_ready (alu_out_ready),
    .alu_out       (alu_out),
    .alu_irq       (alu_irq),
    .alu_drop      (alu_drop),
    .alu_drop_cnt  (alu_drop_cnt),
`ifdef ALU_PARITY_EN
    .alu_out_par   (alu_out_par),
`endif
    .alu_irq_cnt   (alu_irq_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference state
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_out = '0;
  logic             m_irq = 1'b0;
  logic             m_drop = 1'b0;
  logic [CNT_W-1:0] m_dcnt = '0;
  logic [CNT_W-1:0] m_icnt = '0;
  logic [WIDTH-1:0] sb[$];

  typedef struct {
    logic       ea;
    logic       eb;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic       exp_valid;
    logic       exp_drop;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model(input logic ea, input logic eb, input logic [1:0] oa,
                                input logic [1:0] ob, input logic [7:0] a, input logic [7:0] b,
                                output logic prod, output logic [7:0] res, output int idx);
    prod = 1'b0;
    res  = '0;
    idx  = 0;
    if (ea == eb) return;
    if (ea) begin
      idx = int'(oa);
      case (oa)
        2'd0: begin res = a & b;    prod = (b != 8'h00); end
        2'd1: begin res = ~(a & b); prod = (a != 8'hFF) && (b != 8'h03); end
        2'd2: begin res = a | b;    prod = 1'b1; end
        default: begin res = a ^ b; prod = 1'b1; end
      endcase
    end else begin
      idx = 4 + int'(ob);
      case (ob)
        2'd0: begin res = ~(a ^ b); prod = 1'b1; end
        2'd1: begin res = a & b;    prod = (b != 8'h03); end
        2'd2: begin res = ~(a | b); prod = (b != 8'h03); end
        default: begin res = a | b; prod = 1'b1; end
      endcase
    end
  endfunction

  // Called at a falling edge after inputs are set; returns at the next falling edge.
  task automatic tick();
    logic       acc;
    logic       prod;
    logic [7:0] res;
    int         idx;
    logic       set;
    #2;
    check("in_ready", alu_in_ready, !m_valid || alu_out_ready);
    if (m_valid && alu_out_ready) begin
      check("sb_has_beat", sb.size() != 0, 1);
      if (sb.size() != 0) check("sb_beat", alu_out, sb.pop_front());
    end
    acc = alu_in_valid && (!m_valid || alu_out_ready);
    model(alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b, prod, res, idx);
    set = acc && prod && alu_irq_mask[idx] && (res == alu_irq_match[idx*8 +: 8]);
    m_drop = acc && !prod;
    if (acc && prod) begin
      m_out = res;
      sb.push_back(res);
    end
    m_valid = (acc && prod) ? 1'b1 : (m_valid && !alu_out_ready);
    m_irq   = set ? 1'b1 : (alu_irq_clr ? 1'b0 : m_irq);
    if (m_drop && m_dcnt != 16'hFFFF) m_dcnt++;
    if (set && m_icnt != 16'hFFFF) m_icnt++;
    @(posedge alu_clk);
    @(negedge alu_clk);
    check("out_valid", alu_out_valid, m_valid);
    check("out", alu_out, m_out);
    check("drop", alu_drop, m_drop);
    check("drop_cnt", alu_drop_cnt, m_dcnt);
    check("irq", alu_irq, m_irq);
    check("irq_cnt", alu_irq_cnt, m_icnt);
`ifdef ALU_PARITY_EN
    if (alu_out_valid) check("parity", alu_out_par, ^alu_out);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out", alu_out, 0);
    check("rst_out_valid", alu_out_valid, 0);
    check("rst_irq", alu_irq, 0);
    check("rst_drop", alu_drop, 0);
    check("rst_drop_cnt", alu_drop_cnt, 0);
    check("rst_irq_cnt", alu_irq_cnt, 0);
    check("rst_in_ready", alu_in_ready, 1);
    m_valid = 1'b0; m_out = '0; m_irq = 1'b0; m_drop = 1'b0; m_dcnt = '0; m_icnt = '0;
    sb.delete();
    alu_in_valid = 1'b0;
    alu_irq_clr  = 1'b0;
    @(negedge alu_clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic ea, input logic eb, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    alu_in_valid = 1'b1;
    alu_enable_a = ea;
    alu_enable_b = eb;
    alu_op_a     = op;
    alu_op_b     = op;
    alu_in_a     = a;
    alu_in_b     = b;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 8'h50, 8'h0A, 8'h5A, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 8'hFF, 8'h00, 8'h5A, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 8'h0F, 8'hF0, 8'hFF, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 8'hFF, 8'h01, 8'hFF, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 8'h12, 8'h03, 8'hFF, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'd3, 8'hA5, 8'h0F, 8'hAA, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 8'hA5, 8'h0F, 8'h55, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd1, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 8'hFF, 8'h03, 8'h30, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 8'h0F, 8'h30, 8'hC0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 8'h0F, 8'h03, 8'hC0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 2'd3, 8'h0F, 8'hF0, 8'hFF, 1'b1, 1'b0};

    #1;
    do_reset();

    // First result with matching irq slot 3
    alu_irq_match[3*8 +: 8] = 8'h83;
    alu_irq_mask[3] = 1'b1;
    drive(1'b1, 1'b0, 2'd3, 8'h80, 8'h03);
    tick();
    check("t1_out", alu_out, 8'h83);
    check("t1_irq", alu_irq, 1);
    check("t1_irq_cnt", alu_irq_cnt, 1);

    // Vector table, full throughput
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].ea, vecs[i].eb, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      check($sformatf("vec%0d_out", i), alu_out, vecs[i].exp_out);
      check($sformatf("vec%0d_valid", i), alu_out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_drop", i), alu_drop, vecs[i].exp_drop);
    end
    check("irq_sticky", alu_irq, 1);
    alu_in_valid = 1'b0;
    tick();

    // Backpressure: stalled beat holds, next command waits
    drive(1'b1, 1'b0, 2'd2, 8'h11, 8'h22);
    tick();
    alu_out_ready = 1'b0;
    drive(1'b0, 1'b1, 2'd3, 8'h0F, 8'hF0);
    #1;
    check("bp_in_ready", alu_in_ready, 0);
    tick();
    tick();
    check("bp_hold_out", alu_out, 8'h33);
    check("bp_hold_valid", alu_out_valid, 1);
    alu_out_ready = 1'b1;
    tick();
    check("bp_next_out", alu_out, 8'hFF);
    alu_in_valid = 1'b0;
    tick();
    check("bp_sb_empty", sb.size(), 0);

    // Irq set and clear in the same cycle: set wins
    alu_irq_clr = 1'b1;
    tick();
    check("clr_irq", alu_irq, 0);
    drive(1'b1, 1'b0, 2'd3, 8'h80, 8'h03);
    tick();
    check("setclr_irq", alu_irq, 1);
    alu_in_valid = 1'b0;
    tick();
    check("clr_alone_irq", alu_irq, 0);
    alu_irq_clr = 1'b0;

    // Equal enables drop; counter saturates
    do_reset();
    drive(1'b1, 1'b1, 2'd2, 8'h01, 8'h02);
    tick();
    drive(1'b0, 1'b0, 2'd2, 8'h01, 8'h02);
    tick();
    check("drop_cnt_2", alu_drop_cnt, 2);
    check("drop_no_valid", alu_out_valid, 0);
    for (int i = 0; i < 65533; i++) tick();
    check("drop_cnt_sat", alu_drop_cnt, 16'hFFFF);
    tick();
    check("drop_cnt_nowrap", alu_drop_cnt, 16'hFFFF);
    check("drop_pulse_sat", alu_drop, 1);
    alu_in_valid = 1'b0;
    tick();

    // Reset mid-stream with a stalled beat and irq set
    alu_out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'd3, 8'h80, 8'h03);
    tick();
    check("pre_rst_valid", alu_out_valid, 1);
    check("pre_rst_irq", alu_irq, 1);
    do_reset();
    alu_out_ready = 1'b1;
    drive(1'b1, 1'b0, 2'd3, 8'h12, 8'h34);
    tick();
    check("post_rst_out", alu_out, 8'h26);
    check("post_rst_valid", alu_out_valid, 1);
    check("post_rst_irq", alu_irq, 0);
    alu_in_valid = 1'b0;
    tick();
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
